pc_sequencer: RTL and testbench

Next-PC controller that drives the program counter register for instruction fetch. It arbitrates among redirect requesters (exception, exception return, branch, jump) and sequential +4 advance, and applies pipeline stall. It emits a flush pulse so downstream stages can kill wrong-path instructions. It sits between the decode/execute redirect sources and the fetch stage, replacing direct branch/addrIn driving of the PC.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_redirect_arb.sv | 46 ++++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC sequencer: redirect sources, FSM states,
// and the sequential fetch stride.
package pc_pkg;
  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_JUMP   = 3'd1;
  localparam logic [2:0] SRC_BRANCH = 3'd2;
  localparam logic [2:0] SRC_ERET   = 3'd3;
  localparam logic [2:0] SRC_EXC    = 3'd4;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} pcState_t;

  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select among redirect requesters:
// exception > eret > branch > jump. Losers are dropped, never queued.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h8000_0180
) (
  input  logic        exception,
  input  logic        eret,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] epc,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  output logic        take,
  output logic [31:0] target,
  output logic [2:0]  src,
  output logic        misalignRaw
);
  always_comb begin
    take        = 1'b0;
    target      = '0;
    src         = SRC_SEQ;
    misalignRaw = 1'b0;
    if (exception) begin
      take   = 1'b1;
      target = EXC_VEC;
      src    = SRC_EXC;
    end else if (eret) begin
      take        = 1'b1;
      target      = alignWord(epc);
      src         = SRC_ERET;
      misalignRaw = |epc[1:0];
    end else if (branch) begin
      take        = 1'b1;
      target      = alignWord(branchTarget);
      src         = SRC_BRANCH;
      misalignRaw = |branchTarget[1:0];
    end else if (jump) begin
      take        = 1'b1;
      target      = alignWord(jumpTarget);
      src         = SRC_JUMP;
      misalignRaw = |jumpTarget[1:0];
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC register, the BOOT/RUN/STALL/FLUSH
// FSM and the flush counter that kills wrong-path instructions after a redirect.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC      = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exception,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic [2:0]  redirect_src,
  output logic        misalign
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pcState_t    state, stateNxt;
  logic [31:0] pcReg, pcNxt;
  logic [2:0]  srcReg, srcNxt;
  logic        misReg, misNxt;
  logic [2:0]  flushCnt, flushCntNxt;

  logic        take;
  logic [31:0] target;
  logic [2:0]  src;
  logic        misalignRaw;

  pc_redirect_arb #(.EXC_VEC(EXC_VEC)) uArb (
    .exception    (exception),
    .eret         (eret),
    .branch       (branch),
    .jump         (jump),
    .epc          (epc),
    .branchTarget (branch_target),
    .jumpTarget   (jump_target),
    .take         (take),
    .target       (target),
    .src          (src),
    .misalignRaw  (misalignRaw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pcReg    <= RESET_VEC;
      srcReg   <= SRC_SEQ;
      misReg   <= 1'b0;
      flushCnt <= '0;
    end else begin
      state    <= stateNxt;
      pcReg    <= pcNxt;
      srcReg   <= srcNxt;
      misReg   <= misNxt;
      flushCnt <= flushCntNxt;
    end
  end

  // The flush counter runs down even while stalled, so the flush window is
  // always exactly FLUSH_CYCLES long regardless of stall activity.
  always_comb begin
    stateNxt    = state;
    pcNxt       = pcReg;
    srcNxt      = srcReg;
    misNxt      = 1'b0;
    flushCntNxt = (flushCnt != 3'd0) ? flushCnt - 3'd1 : 3'd0;
    if (state == BOOT) begin
      // Requests are ignored until the first valid fetch of RESET_VEC issues.
      stateNxt = RUN;
    end else if (take) begin
      pcNxt       = target;
      srcNxt      = src;
      misNxt      = misalignRaw;
      flushCntNxt = FLUSH_LOAD;
      stateNxt    = FLUSH;
    end else if (stall) begin
      stateNxt = (flushCntNxt != 3'd0) ? FLUSH : STALL;
    end else begin
      pcNxt    = pcReg + 32'(INSTR_BYTES);
      srcNxt   = SRC_SEQ;
      stateNxt = (flushCntNxt != 3'd0) ? FLUSH : RUN;
    end
  end

  assign pc_out       = pcReg;
  assign pc_valid     = (state != BOOT);
  assign flush        = (flushCnt != 3'd0);
  assign redirect_src = srcReg;
  assign misalign     = misReg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of per-cycle stimulus/expected
// records driven through a scoreboard queue, plus a back-to-back redirect run.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, jump, branch, eret, exception;
  logic [31:0] jump_target, branch_target, epc;
  logic [31:0] pc_out;
  logic        pc_valid, flush, misalign;
  logic [2:0]  redirect_src;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch        (branch),
    .branch_target (branch_target),
    .eret          (eret),
    .epc           (epc),
    .exception     (exception),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .flush         (flush),
    .redirect_src  (redirect_src),
    .misalign      (misalign)
  );

  typedef struct {
    logic        rst, stl, exc, ert, br, jmp;
    logic [31:0] bt, jt, ep;
    logic [31:0] ePc;
    logic        eVld, eFl;
    logic [2:0]  eSrc;
    logic        eMis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        vld, fl;
    logic [2:0]  src;
    logic        mis;
  } exp_t;

  exp_t expQ[$];
  vec_t tbl[$];
  int   nCmp = 0;
  int   nBad = 0;
  int   stepNo = 0;

  function automatic vec_t mk(input logic r, s, ex, er, b, j,
                              input logic [31:0] bt, jt, ep, pc,
                              input logic v, f, input logic [2:0] sr, input logic m);
    vec_t t;
    t.rst = r; t.stl = s; t.exc = ex; t.ert = er; t.br = b; t.jmp = j;
    t.bt = bt; t.jt = jt; t.ep = ep;
    t.ePc = pc; t.eVld = v; t.eFl = f; t.eSrc = sr; t.eMis = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL step %0d %s: got %h expected %h", stepNo, name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    reset = v.rst; stall = v.stl; exception = v.exc; eret = v.ert;
    branch = v.br; jump = v.jmp;
    branch_target = v.bt; jump_target = v.jt; epc = v.ep;
    e.pc = v.ePc; e.vld = v.eVld; e.fl = v.eFl; e.src = v.eSrc; e.mis = v.eMis;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    chk("pc_out",       pc_out,              e.pc);
    chk("pc_valid",     32'(pc_valid),       32'(e.vld));
    chk("flush",        32'(flush),          32'(e.fl));
    chk("redirect_src", 32'(redirect_src),   32'(e.src));
    chk("misalign",     32'(misalign),       32'(e.mis));
    stepNo++;
  endtask

  initial begin
    //               rst stl exc ert br jmp  bt            jt            epc           expPc         v  f  src m
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0004, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0008, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_000C, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0010, 1, 0, 0, 0));
    // stall at 0x10, branch on the second stall cycle, stall persists
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0010, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h40,       32'h0,        32'h0,      32'h0000_0040, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0040, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0040, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0044, 1, 0, 0, 0));
    // taken branch
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hCAFE_F00C, 32'h0,       32'h0,      32'hCAFE_F00C, 1, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'hCAFE_F010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'hCAFE_F014, 1, 0, 0, 0));
    // priority: exception wins, then jump during flush extends it
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 32'h200,      32'h100,      32'h0,      32'h8000_0180, 1, 1, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h100,      32'h0,      32'h0000_0100, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0104, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0108, 1, 0, 0, 0));
    // eret beats branch
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h200,      32'h0,        32'h300,    32'h0000_0300, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0304, 1, 1, 0, 0));
    // misaligned jump during flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'hCAFE_F00E, 32'h0,     32'hCAFE_F00C, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'hCAFE_F010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'hCAFE_F014, 1, 0, 0, 0));
    // address wrap
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFD, 32'h0,       32'h0,      32'hFFFF_FFFC, 1, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0004, 1, 0, 0, 0));
    // reset in the first flush cycle after a misaligned eret
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h502,    32'h0000_0500, 1, 1, 3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0004, 1, 0, 0, 0));
    // reset with stall held, then exception overriding stall
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0000_0000, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h8000_0180, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h8000_0180, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h8000_0180, 1, 0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h8000_0184, 1, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Back-to-back redirects keep flush asserted without a gap.
    step(mk(0, 0, 0, 0, 1, 0, 32'h1000, 32'h0,    32'h0, 32'h0000_1000, 1, 1, 2, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h2000, 32'h0,    32'h0, 32'h0000_2000, 1, 1, 2, 0));
    step(mk(0, 0, 0, 0, 0, 1, 32'h0,    32'h3000, 32'h0, 32'h0000_3000, 1, 1, 1, 0));
    step(mk(0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    32'h0, 32'h0000_3004, 1, 1, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 32'h0,    32'h0,    32'h0, 32'h0000_3008, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
